// File: rtl/countdown_pkg.sv
// -----------------------------------------------------------------------------
// countdown_pkg
// Shared definitions for the bomb countdown timer:
//   - state_t : timer phase encoding as seen on the 'state' output
//               (0 IDLE, 1 RUNNING, 2 PAUSED, 3 DONE)
//   - sat_sub : subtraction that clamps at zero instead of wrapping
// -----------------------------------------------------------------------------
package countdown_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2,
    DONE    = 2'd3
  } state_t;

  // Operands are widened to 32 bits so that a subtrahend of PENALTY+1 can
  // never overflow the count width before the comparison is made.
  function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
    if (a > b) begin
      return a - b;
    end
    return 32'd0;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
// Prescaler that divides clk by TICK_DIV while enabled.
// Ports:
//   clk             in  : rising-edge clock
//   countdown_reset in  : asynchronous active-high reset
//   enable          in  : advance the prescaler this cycle
//   clear           in  : force the prescaler back to 0 (wins over enable)
//   wrap            out : combinational, high in the cycle whose edge wraps
//                         the prescaler; lets the parent decrement its count
//                         on the same edge that raises tick
//   tick            out : registered one-cycle pulse following each wrap
// -----------------------------------------------------------------------------
module tick_gen #(
  parameter int TICK_DIV = 50000000
) (
  input  logic clk,
  input  logic countdown_reset,
  input  logic enable,
  input  logic clear,
  output logic wrap,
  output logic tick
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] pre_q;
  logic [PW-1:0] pre_d;
  logic          tick_q;

  assign wrap = enable && !clear && (pre_q == LAST);
  assign tick = tick_q;

  always_comb begin
    pre_d = pre_q;
    if (clear) begin
      pre_d = '0;
    end else if (enable) begin
      pre_d = wrap ? '0 : pre_q + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge countdown_reset) begin
    if (countdown_reset) begin
      pre_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      tick_q <= wrap;
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// -----------------------------------------------------------------------------
// countdown_timer
// Bomb timer for the defuse game: counts down one unit every TICK_DIV clocks
// while RUNNING, supports pause/resume, saturating penalties, a defuse freeze
// and sticky expired/defused status.
// Ports:
//   clk             in  : rising-edge clock
//   countdown_reset in  : asynchronous active-high reset
//   load            in  : load load_value, return to IDLE, clear status
//   load_value      in  : [WIDTH] value captured on load
//   start           in  : start from IDLE or resume from PAUSED
//   pause           in  : RUNNING -> PAUSED
//   penalty         in  : subtract PENALTY, clamped at 0
//   defuse          in  : freeze as defused (RUNNING or PAUSED)
//   count           out : [WIDTH] remaining time
//   state           out : [2] 0 IDLE, 1 RUNNING, 2 PAUSED, 3 DONE
//   tick            out : one-cycle pulse per prescaler wrap
//   expired         out : sticky, count reached 0 while armed
//   expire_pulse    out : one-cycle pulse on entry to DONE via expiry
//   defused         out : sticky, DONE entered via defuse
// -----------------------------------------------------------------------------
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int TICK_DIV     = 50000000,
  parameter int PENALTY      = 5,
  parameter int DEFAULT_LOAD = 15
) (
  input  logic             clk,
  input  logic             countdown_reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             pause,
  input  logic             penalty,
  input  logic             defuse,
  output logic [WIDTH-1:0] count,
  output logic [1:0]       state,
  output logic             tick,
  output logic             expired,
  output logic             expire_pulse,
  output logic             defused
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             expired_q, expired_d;
  logic             defused_q, defused_d;
  logic             expire_pulse_q, expire_pulse_d;

  logic             tick_enable;
  logic             tick_clear;
  logic             wrap;
  logic [31:0]      run_dec;
  logic [WIDTH-1:0] run_count;
  logic [WIDTH-1:0] pen_count;

  // The prescaler only runs when the timer genuinely stays armed this cycle;
  // load and defuse both pre-empt the tick.
  assign tick_enable = (state_q == RUNNING) && !load && !defuse;
  assign tick_clear  = load || ((state_q == IDLE) && start);

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk            (clk),
    .countdown_reset(countdown_reset),
    .enable         (tick_enable),
    .clear          (tick_clear),
    .wrap           (wrap),
    .tick           (tick)
  );

  // A coincident tick and penalty remove PENALTY+1 in one step.
  assign run_dec   = (wrap ? 32'd1 : 32'd0) + (penalty ? 32'(PENALTY) : 32'd0);
  assign run_count = WIDTH'(sat_sub(32'(count_q), run_dec));
  assign pen_count = WIDTH'(sat_sub(32'(count_q), 32'(PENALTY)));

  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    expired_d      = expired_q;
    defused_d      = defused_q;
    expire_pulse_d = 1'b0;

    if (load) begin
      count_d   = load_value;
      state_d   = IDLE;
      expired_d = 1'b0;
      defused_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (count_q == '0) begin
              state_d        = DONE;
              expired_d      = 1'b1;
              expire_pulse_d = 1'b1;
            end else begin
              state_d = RUNNING;
            end
          end
        end

        RUNNING: begin
          if (defuse) begin
            state_d   = DONE;
            defused_d = 1'b1;
          end else begin
            if (run_dec != 32'd0) begin
              count_d = run_count;
            end
            // Expiry outranks a simultaneous pause.
            if ((run_dec != 32'd0) && (run_count == '0)) begin
              state_d        = DONE;
              expired_d      = 1'b1;
              expire_pulse_d = 1'b1;
            end else if (pause) begin
              state_d = PAUSED;
            end
          end
        end

        PAUSED: begin
          if (defuse) begin
            state_d   = DONE;
            defused_d = 1'b1;
          end else if (penalty && (pen_count == '0)) begin
            count_d        = '0;
            state_d        = DONE;
            expired_d      = 1'b1;
            expire_pulse_d = 1'b1;
          end else begin
            if (penalty) begin
              count_d = pen_count;
            end
            if (start) begin
              state_d = RUNNING;
            end
          end
        end

        default: begin
          // DONE: frozen until load or reset.
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge countdown_reset) begin
    if (countdown_reset) begin
      state_q        <= IDLE;
      count_q        <= WIDTH'(DEFAULT_LOAD);
      expired_q      <= 1'b0;
      defused_q      <= 1'b0;
      expire_pulse_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      expired_q      <= expired_d;
      defused_q      <= defused_d;
      expire_pulse_q <= expire_pulse_d;
    end
  end

  assign count        = count_q;
  assign state        = state_q;
  assign expired      = expired_q;
  assign defused      = defused_q;
  assign expire_pulse = expire_pulse_q;

endmodule

// File: tb/tb_countdown_timer.sv
// -----------------------------------------------------------------------------
// tb_countdown_timer
// Self-checking bench for countdown_timer (WIDTH=8, TICK_DIV=4, PENALTY=5,
// DEFAULT_LOAD=15). A driver applies one input vector per cycle and pushes the
// reference model's expected outputs; a monitor pops and compares after each
// rising edge. Directed scenarios are followed by random traffic.
// -----------------------------------------------------------------------------
module tb_countdown_timer;

  localparam int WIDTH        = 8;
  localparam int TICK_DIV     = 4;
  localparam int PENALTY      = 5;
  localparam int DEFAULT_LOAD = 15;

  localparam int M_IDLE    = 0;
  localparam int M_RUNNING = 1;
  localparam int M_PAUSED  = 2;
  localparam int M_DONE    = 3;

  logic             clk = 1'b0;
  logic             countdown_reset;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             start;
  logic             pause;
  logic             penalty;
  logic             defuse;
  logic [WIDTH-1:0] count;
  logic [1:0]       state;
  logic             tick;
  logic             expired;
  logic             expire_pulse;
  logic             defused;

  countdown_timer #(
    .WIDTH       (WIDTH),
    .TICK_DIV    (TICK_DIV),
    .PENALTY     (PENALTY),
    .DEFAULT_LOAD(DEFAULT_LOAD)
  ) dut (
    .clk            (clk),
    .countdown_reset(countdown_reset),
    .load           (load),
    .load_value     (load_value),
    .start          (start),
    .pause          (pause),
    .penalty        (penalty),
    .defuse         (defuse),
    .count          (count),
    .state          (state),
    .tick           (tick),
    .expired        (expired),
    .expire_pulse   (expire_pulse),
    .defused        (defused)
  );

  always #5 clk = ~clk;

  typedef struct {
    int count;
    int state;
    int tick;
    int expired;
    int pulse;
    int defused;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int txn    = 0;

  // Reference model: remaining time, mode, and cycles spent running since the
  // last whole unit elapsed.
  int m_count;
  int m_mode;
  int m_elapsed;
  int m_expired;
  int m_defused;

  task automatic chk(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic model_reset();
    m_count   = DEFAULT_LOAD;
    m_mode    = M_IDLE;
    m_elapsed = 0;
    m_expired = 0;
    m_defused = 0;
  endtask

  function automatic int floor0(input int v);
    return (v < 0) ? 0 : v;
  endfunction

  // Advance the model one clock with the given inputs; returns expected outputs.
  task automatic model_step(input bit ld, input int lv, input bit st, input bit ps,
                            input bit pn, input bit df, output exp_t e);
    int t;
    int take;
    t = 0;
    e.pulse = 0;
    if (ld) begin
      m_count = lv; m_mode = M_IDLE; m_elapsed = 0; m_expired = 0; m_defused = 0;
    end else if (m_mode == M_IDLE) begin
      if (st) begin
        if (m_count == 0) begin
          m_mode = M_DONE; m_expired = 1; e.pulse = 1;
        end else begin
          m_mode = M_RUNNING; m_elapsed = 0;
        end
      end
    end else if (m_mode == M_RUNNING) begin
      if (df) begin
        m_mode = M_DONE; m_defused = 1;
      end else begin
        m_elapsed = m_elapsed + 1;
        if (m_elapsed == TICK_DIV) begin
          t = 1; m_elapsed = 0;
        end
        take = t + (pn ? PENALTY : 0);
        m_count = floor0(m_count - take);
        if (take > 0 && m_count == 0) begin
          m_mode = M_DONE; m_expired = 1; e.pulse = 1;
        end else if (ps) begin
          m_mode = M_PAUSED;
        end
      end
    end else if (m_mode == M_PAUSED) begin
      if (df) begin
        m_mode = M_DONE; m_defused = 1;
      end else begin
        if (pn) m_count = floor0(m_count - PENALTY);
        if (pn && m_count == 0) begin
          m_mode = M_DONE; m_expired = 1; e.pulse = 1;
        end else if (st) begin
          m_mode = M_RUNNING;
        end
      end
    end
    e.count   = m_count;
    e.state   = m_mode;
    e.tick    = t;
    e.expired = m_expired;
    e.defused = m_defused;
  endtask

  // One transaction: drive at the falling edge, predict, wait past the rise.
  task automatic step(input bit ld, input int lv, input bit st, input bit ps,
                      input bit pn, input bit df);
    exp_t e;
    @(negedge clk);
    load       = ld;
    load_value = WIDTH'(lv);
    start      = st;
    pause      = ps;
    penalty    = pn;
    defuse     = df;
    model_step(ld, lv, st, ps, pn, df, e);
    exp_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_count"}, int'(count), DEFAULT_LOAD);
    chk({tag, "_state"}, int'(state), M_IDLE);
    chk({tag, "_flags"}, int'({tick, expired, expire_pulse, defused}), 0);
  endtask

  // Asserts reset between edges and checks it acts without a clock.
  task automatic async_reset();
    @(negedge clk);
    load = 0; start = 0; pause = 0; penalty = 0; defuse = 0;
    #2;
    countdown_reset = 1'b1;
    #1;
    check_reset_values("async_reset");
    model_reset();
    @(negedge clk);
    countdown_reset = 1'b0;
  endtask

  // Monitor: one comparison per clocked transaction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        txn++;
        checks++;
        if ({int'(count), int'(state), int'(tick), int'(expired), int'(expire_pulse), int'(defused)}
            !== {e.count, e.state, e.tick, e.expired, e.pulse, e.defused}) begin
          errors++;
          $display("FAIL txn %0d: got count=%0d state=%0d tick=%0d exp=%0d pulse=%0d def=%0d expected count=%0d state=%0d tick=%0d exp=%0d pulse=%0d def=%0d",
                   txn, count, state, tick, expired, expire_pulse, defused,
                   e.count, e.state, e.tick, e.expired, e.pulse, e.defused);
        end else begin
          $display("txn %0d ok: count=%0d state=%0d tick=%0d exp=%0d pulse=%0d def=%0d",
                   txn, count, state, tick, expired, expire_pulse, defused);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    countdown_reset = 1'b1;
    load = 0; load_value = '0; start = 0; pause = 0; penalty = 0; defuse = 0;
    model_reset();
    #12;
    check_reset_values("por");
    @(negedge clk);
    countdown_reset = 1'b0;

    // Scenario 1: full countdown from the default load.
    step(0, 0, 1, 0, 0, 0);
    idle(4);
    chk("s1_count_after_4", int'(count), 14);
    idle(55);
    chk("s1_count_before_zero", int'(count), 1);
    idle(1);
    chk("s1_count_zero", int'(count), 0);
    chk("s1_state_done", int'(state), M_DONE);
    chk("s1_pulse_on", int'(expire_pulse), 1);
    idle(1);
    chk("s1_pulse_off", int'(expire_pulse), 0);
    idle(5);
    chk("s1_count_hold", int'(count), 0);
    chk("s1_expired_sticky", int'(expired), 1);

    // Scenario 2: pause keeps count and prescaler.
    step(1, 10, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    idle(8);
    chk("s2_count_8", int'(count), 8);
    step(0, 0, 0, 1, 0, 0);
    idle(20);
    chk("s2_paused_count", int'(count), 8);
    chk("s2_paused_state", int'(state), M_PAUSED);
    step(0, 0, 1, 0, 0, 0);
    idle(4);
    chk("s2_resumed_count", int'(count), 7);

    // Scenario 3: penalties, saturation, coincident tick.
    step(0, 0, 0, 0, 1, 0);
    chk("s3_pen_7_to_2", int'(count), 2);
    step(0, 0, 0, 0, 1, 0);
    chk("s3_pen_sat0", int'(count), 0);
    chk("s3_expired", int'(expired), 1);
    chk("s3_done", int'(state), M_DONE);
    step(1, 13, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    idle(16);
    chk("s3_count_9", int'(count), 9);
    idle(3);
    step(0, 0, 0, 0, 1, 0);
    chk("s3_tick_and_pen", int'(count), 3);
    chk("s3_tick_seen", int'(tick), 1);

    // Scenario 4: defuse beats the expiring tick.
    step(1, 2, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    idle(7);
    step(0, 0, 0, 0, 0, 1);
    chk("s4_defused", int'(defused), 1);
    chk("s4_not_expired", int'(expired), 0);
    chk("s4_count_frozen", int'(count), 1);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    chk("s4_done_hold", int'(count), 1);
    step(1, 20, 0, 0, 0, 0);
    chk("s4_reload", int'(count), 20);
    chk("s4_reload_flags", int'({expired, defused}), 0);

    // Scenario 5: async reset mid-run.
    step(0, 0, 1, 0, 0, 0);
    idle(6);
    async_reset();
    step(0, 0, 1, 0, 0, 0);
    idle(4);
    chk("s5_count_14", int'(count), 14);

    // Scenario 6: zero load corner cases.
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    chk("s6_zero_start", int'({state, expired, expire_pulse}), 15);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    chk("s6_idle_defuse", int'(state), M_IDLE);

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 99) < 3),
           int'($urandom_range(0, 40)),
           ($urandom_range(0, 99) < 15),
           ($urandom_range(0, 99) < 5),
           ($urandom_range(0, 99) < 5),
           ($urandom_range(0, 99) < 2));
    end

    @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Parametrised successor to the fixed-15 countdown; used as the defuse game's bomb timer.
- Adds an internal seconds prescaler, start/pause/resume control, a saturating penalty subtract, a defuse freeze, and sticky expired/defused status.
- Output count feeds the existing bcd/hex_decoder display chain.
- Output status feeds the game FSM.

Parameters:
WIDTH, 8, bit width of count and load_value.
TICK_DIV, 50000000, clk cycles per one-unit decrement; must be >= 1.
PENALTY, 5, units subtracted per penalty pulse; must be < 2**WIDTH.
DEFAULT_LOAD, 15, count value after reset.

Ports:
clk  input  1  rising-edge clock, sole clock domain.
countdown_reset  input  1  asynchronous, active-high reset.
load  input  1  load load_value and return to IDLE.
load_value  input  WIDTH  value captured on load.
start  input  1  start from IDLE, or resume from PAUSED.
pause  input  1  RUNNING to PAUSED.
penalty  input  1  subtract PENALTY, saturating at 0.
defuse  input  1  freeze the timer as defused.
count  output  WIDTH  current remaining time.
state  output  2  0 IDLE, 1 RUNNING, 2 PAUSED, 3 DONE.
tick  output  1  one-cycle pulse on each prescaler wrap.
expired  output  1  sticky; count reached 0 while armed.
expire_pulse  output  1  one cycle, on entry to DONE via expiry.
defused  output  1  sticky; DONE entered via defuse.

Behaviour:
- Reset (asynchronous, takes effect immediately with no clock edge):
  - count=DEFAULT_LOAD, state=IDLE, prescaler=0.
  - tick, expired, expire_pulse, defused all 0.
- All other updates occur on the rising edge of clk. Outputs are registered.
- Per-cycle priority: load > defuse > penalty/tick > start/pause.
- load (any state):
  - count<=load_value, state<=IDLE, prescaler<=0.
  - expired and defused cleared.
- IDLE:
  - start: go to RUNNING and clear the prescaler.
  - If count==0 when start is asserted, go directly to DONE with expired=1 and expire_pulse=1.
  - pause, penalty, defuse: ignored.
- Prescaler:
  - Width is max(1, clog2(TICK_DIV)). It increments only in RUNNING.
  - At TICK_DIV-1 it wraps to 0, and tick=1 on the following cycle, aligned with the count decrement.
  - TICK_DIV=1 gives a decrement every RUNNING cycle.
- RUNNING:
  - Tick: count<=count-1.
  - Penalty: count<=sat0(count-PENALTY).
  - Tick and penalty in the same cycle: count<=sat0(count-PENALTY-1).
  - Any update that yields 0 goes to DONE, sets expired=1, and pulses expire_pulse for exactly one cycle. count holds 0.
  - pause: go to PAUSED. The prescaler value is retained. start is ignored.
- PAUSED:
  - Prescaler and count are frozen.
  - start: resume in RUNNING from the retained prescaler value.
  - Penalty still applies, with the same expiry rule.
- defuse (RUNNING or PAUSED):
  - Go to DONE with defused=1. count is frozen at its current value.
  - Wins over an expiring tick or penalty in the same cycle: expired stays 0.
- DONE:
  - Holds until load or reset. start, pause, penalty, defuse and ticks are ignored.
  - Exactly one of expired/defused is 1.
- No wrap-around: count never underflows below 0.

Decomposition:
- Shared package countdown_pkg holds:
  - the state encoding constants IDLE/RUNNING/PAUSED/DONE;
  - a sat_sub helper function.
- One natural sub-module: tick_gen.
  - Inputs: clk, countdown_reset, enable, clear.
  - Output: tick.
  - Parameter: TICK_DIV.
- The FSM and count datapath stay in countdown_timer.

Test Plan:
All scenarios use WIDTH=8, TICK_DIV=4, PENALTY=5, DEFAULT_LOAD=15.
1. Reset then start -> count=14 after 4 clks; count=0 after 60 clks; state=3, expired=1, expire_pulse high exactly 1 cycle; further clks leave count=0.
2. load 10, start, 8 clks -> count=8; pause then 20 clks -> count=8, state=2; start, 4 clks -> count=7.
3. Running at count=7, penalty -> 2; penalty again -> count=0, expired=1, state=3. Penalty coincident with a tick at count=9 -> 3.
4. count=1, defuse on the same edge as the final tick -> defused=1, expired=0, count=1, state=3. Later start/penalty have no effect; load 20 -> IDLE, count=20, flags cleared.
5. countdown_reset asserted mid-RUNNING between clock edges -> count=15, state=0, all flags 0 immediately. Deassert; next start behaves as scenario 1.
6. load 0 then start -> next edge state=3, expired=1, expire_pulse=1. load 0 then defuse in IDLE -> ignored, state=0.
